// File: rtl/cpu_hazard_pkg.sv
// Shared types and constants for the pipeline hazard stall unit.
package cpu_hazard_pkg;

    // Controller states: normal flow, or mid-way through a multi-cycle load-use stall.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_t;

    // Architectural zero register; never a real producer, so never a hazard source.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Legal range for the number of bubbles per load-use hazard (lu_cnt is 2 bits).
    localparam int LU_STALLS_MIN = 1;
    localparam int LU_STALLS_MAX = 3;

    // Force an out-of-range stall count into the legal range so lu_cnt cannot overflow.
    function automatic int clamp_lu_stalls(input int n);
        if (n < LU_STALLS_MIN) return LU_STALLS_MIN;
        if (n > LU_STALLS_MAX) return LU_STALLS_MAX;
        return n;
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Enable-gated free-running counter that wraps modulo 2^W and clears on reset.
module hazard_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count one per enabled cycle; natural wrap at the top of the range.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller for the 5-stage core: load-use stalls, taken-branch
// flushes and data-memory freezes. Optional performance counters are compiled in
// with the HAZARD_PERF_CNT_EN macro (adds stall_cycles and flush_events ports).
module hazard_stall_unit
    import cpu_hazard_pkg::*;
#(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1_IF_ID,
    input  logic [REG_ADDR_W-1:0] Rs2_IF_ID,
    input  logic                  uses_rs1_IF_ID,
    input  logic                  uses_rs2_IF_ID,
    input  logic [REG_ADDR_W-1:0] Rd_ID_EXE,
    input  logic                  mem_read_ID_EXE,
    input  logic                  branch_taken_EXE_MEM,
    input  logic                  dmem_req_EXE_MEM,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_exe_write,
    output logic                  exe_mem_write,
    output logic                  mem_wb_write,
    output logic                  if_id_flush,
    output logic                  id_exe_bubble,
    output logic                  exe_mem_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events,
`endif
    output logic                  stall_active
);

    // Effective bubble count, and the lu_cnt value loaded when a multi-cycle stall begins.
    localparam int         LU_N    = clamp_lu_stalls(LOAD_USE_STALLS);
    localparam logic [1:0] LU_INIT = 2'(LU_N - 1);

    hz_state_t  state, state_next;
    logic [1:0] lu_cnt, lu_cnt_next;
    logic       hazard_lu;
    logic       freeze;

    // Hazard detection: a load in EX feeding a register the decode instruction actually reads.
    always_comb begin
        hazard_lu = mem_read_ID_EXE && (Rd_ID_EXE != REG_ADDR_W'(REG_X0)) &&
                    ((uses_rs1_IF_ID && (Rd_ID_EXE == Rs1_IF_ID)) ||
                     (uses_rs2_IF_ID && (Rd_ID_EXE == Rs2_IF_ID)));
        freeze    = dmem_req_EXE_MEM && !dmem_ready;
    end

    // State register; reset abandons any stall in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= RUN;
            lu_cnt <= '0;
        end else begin
            state  <= state_next;
            lu_cnt <= lu_cnt_next;
        end
    end

    // Next state and outputs, in priority order freeze > branch > LU_STALL > new hazard.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next    = state;
        lu_cnt_next   = lu_cnt;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_exe_write  = 1'b1;
        exe_mem_write = 1'b1;
        mem_wb_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_exe_bubble = 1'b0;
        exe_mem_flush = 1'b0;
        stall_active  = 1'b0;

        if (freeze) begin
            // Whole pipeline holds; FSM and counter keep their values.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_write  = 1'b0;
            exe_mem_write = 1'b0;
            mem_wb_write  = 1'b0;
            stall_active  = 1'b1;
        end else if (branch_taken_EXE_MEM) begin
            // Squash the three wrong-path instructions; any pending load-use stall is moot.
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
            exe_mem_flush = 1'b1;
            state_next    = RUN;
            lu_cnt_next   = '0;
        end else if (state == LU_STALL) begin
            // Remaining bubbles of a multi-cycle stall; hazard_lu is not re-evaluated.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_bubble = 1'b1;
            stall_active  = 1'b1;
            if (lu_cnt <= 2'd1) begin
                state_next  = RUN;
                lu_cnt_next = '0;
            end else begin
                lu_cnt_next = lu_cnt - 2'd1;
            end
        end else if (hazard_lu) begin
            // First bubble: hold PC and IF/ID, inject a NOP into ID/EX.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_bubble = 1'b1;
            stall_active  = 1'b1;
            if (LU_N > 1) begin
                state_next  = LU_STALL;
                lu_cnt_next = LU_INIT;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_active),
        .count (stall_cycles)
    );

    hazard_perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (branch_taken_EXE_MEM && !freeze),
        .count (flush_events)
    );
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: three instances (LOAD_USE_STALLS = 1, 2, 3)
// share one directed stimulus stream; a scoreboard queue carries expected output vectors
// to a negedge monitor. Counter checks are compiled when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_stall_unit;

    // Output vector order: {pc, if_id_w, id_exe_w, exe_mem_w, mem_wb_w, if_id_fl, bubble, exe_mem_fl, stall}
    localparam logic [8:0] IDL = 9'b11111_000_0;
    localparam logic [8:0] STL = 9'b00111_010_1;
    localparam logic [8:0] FRZ = 9'b00000_000_1;
    localparam logic [8:0] FLS = 9'b11111_111_0;

    typedef struct {
        logic [8:0] e1;
        logic [8:0] e2;
        logic [8:0] e3;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, dq, dr;

    logic [8:0] act1, act2, act3;
    logic       pw1, iw1, ew1, mw1, ww1, ff1, bb1, xf1, sa1;
    logic       pw2, iw2, ew2, mw2, ww2, ff2, bb2, xf2, sa2;
    logic       pw3, iw3, ew3, mw3, ww3, ff3, bb3, xf3, sa3;
`ifdef HAZARD_PERF_CNT_EN
    logic [3:0] sc1, fe1, sc2, fe2, sc3, fe3;
`endif

    always #5 clk = ~clk;

    hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .Rs1_IF_ID(rs1), .Rs2_IF_ID(rs2),
        .uses_rs1_IF_ID(u1), .uses_rs2_IF_ID(u2), .Rd_ID_EXE(rd), .mem_read_ID_EXE(mr),
        .branch_taken_EXE_MEM(br), .dmem_req_EXE_MEM(dq), .dmem_ready(dr),
        .pc_write(pw1), .if_id_write(iw1), .id_exe_write(ew1), .exe_mem_write(mw1),
        .mem_wb_write(ww1), .if_id_flush(ff1), .id_exe_bubble(bb1), .exe_mem_flush(xf1),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(sc1), .flush_events(fe1),
`endif
        .stall_active(sa1));

    hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .Rs1_IF_ID(rs1), .Rs2_IF_ID(rs2),
        .uses_rs1_IF_ID(u1), .uses_rs2_IF_ID(u2), .Rd_ID_EXE(rd), .mem_read_ID_EXE(mr),
        .branch_taken_EXE_MEM(br), .dmem_req_EXE_MEM(dq), .dmem_ready(dr),
        .pc_write(pw2), .if_id_write(iw2), .id_exe_write(ew2), .exe_mem_write(mw2),
        .mem_wb_write(ww2), .if_id_flush(ff2), .id_exe_bubble(bb2), .exe_mem_flush(xf2),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(sc2), .flush_events(fe2),
`endif
        .stall_active(sa2));

    hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .Rs1_IF_ID(rs1), .Rs2_IF_ID(rs2),
        .uses_rs1_IF_ID(u1), .uses_rs2_IF_ID(u2), .Rd_ID_EXE(rd), .mem_read_ID_EXE(mr),
        .branch_taken_EXE_MEM(br), .dmem_req_EXE_MEM(dq), .dmem_ready(dr),
        .pc_write(pw3), .if_id_write(iw3), .id_exe_write(ew3), .exe_mem_write(mw3),
        .mem_wb_write(ww3), .if_id_flush(ff3), .id_exe_bubble(bb3), .exe_mem_flush(xf3),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(sc3), .flush_events(fe3),
`endif
        .stall_active(sa3));

    assign act1 = {pw1, iw1, ew1, mw1, ww1, ff1, bb1, xf1, sa1};
    assign act2 = {pw2, iw2, ew2, mw2, ww2, ff2, bb2, xf2, sa2};
    assign act3 = {pw3, iw3, ew3, mw3, ww3, ff3, bb3, xf3, sa3};

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    // One stimulus cycle: drive inputs just after the edge, then queue what each instance must show.
    task automatic cyc(input logic rst, input logic [4:0] i_rs1, input logic [4:0] i_rs2,
                       input logic i_u1, input logic i_u2, input logic [4:0] i_rd, input logic i_mr,
                       input logic i_br, input logic i_dq, input logic i_dr,
                       input logic [8:0] x1, input logic [8:0] x2, input logic [8:0] x3,
                       input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; rs1 = i_rs1; rs2 = i_rs2; u1 = i_u1; u2 = i_u2;
        rd = i_rd; mr = i_mr; br = i_br; dq = i_dq; dr = i_dr;
        e.e1 = x1; e.e2 = x2; e.e3 = x3; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: compare every queued expectation against all three instances mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "/n1"}, 32'(act1), 32'(e.e1));
            check({e.name, "/n2"}, 32'(act2), 32'(e.e2));
            check({e.name, "/n3"}, 32'(act3), 32'(e.e3));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rs1 = '0; rs2 = '0; u1 = 1'b0; u2 = 1'b0;
        rd = '0; mr = 1'b0; br = 1'b0; dq = 1'b0; dr = 1'b1;
        repeat (3) @(posedge clk);

        //   rst rs1 rs2 u1 u2 rd mr br dq dr    n1   n2   n3
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,       IDL, IDL, IDL, "reset_idle");
        cyc(1, 5, 0, 1, 0, 5, 1, 0, 0, 1,       STL, STL, STL, "lu_rs1_first");
        cyc(1, 5, 0, 1, 0, 0, 0, 0, 0, 1,       IDL, STL, STL, "lu_second");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,       IDL, IDL, STL, "lu_third");
        cyc(1, 0, 0, 1, 0, 0, 1, 0, 0, 1,       IDL, IDL, IDL, "load_x0");
        cyc(1, 3, 5, 1, 0, 5, 1, 0, 0, 1,       IDL, IDL, IDL, "rs2_unused");
        cyc(1, 3, 5, 1, 1, 5, 1, 0, 0, 1,       STL, STL, STL, "lu_rs2");
        cyc(1, 3, 5, 1, 1, 0, 0, 1, 0, 1,       FLS, FLS, FLS, "branch_in_stall");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,       IDL, IDL, IDL, "after_branch");
        cyc(1, 5, 0, 1, 0, 5, 1, 0, 0, 1,       STL, STL, STL, "pre_freeze");
        for (int i = 0; i < 3; i++)
            cyc(1, 5, 0, 1, 0, 0, 0, 0, 1, 0,   FRZ, FRZ, FRZ, "freeze");
        cyc(1, 5, 0, 1, 0, 0, 0, 0, 1, 1,       IDL, STL, STL, "resume_1");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,       IDL, IDL, STL, "resume_2");
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,       FRZ, FRZ, FRZ, "freeze_over_branch");
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 1,       FLS, FLS, FLS, "branch_after_freeze");
        cyc(1, 5, 0, 1, 0, 5, 1, 0, 1, 0,       FRZ, FRZ, FRZ, "freeze_over_hazard");
        cyc(1, 5, 0, 1, 0, 5, 1, 0, 0, 1,       STL, STL, STL, "hazard_after_freeze");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,       IDL, STL, STL, "reset_asserted_in_stall");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,       IDL, IDL, IDL, "reset_mid_stall");
        cyc(1, 5, 0, 1, 0, 5, 1, 0, 0, 1,       STL, STL, STL, "b2b_load_1");
        cyc(1, 6, 0, 1, 0, 6, 1, 0, 0, 1,       STL, STL, STL, "b2b_load_2");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,       IDL, IDL, STL, "b2b_tail");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,       IDL, IDL, IDL, "final_idle");

`ifdef HAZARD_PERF_CNT_EN
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,       IDL, IDL, IDL, "perf_clear");
        for (int i = 0; i < 17; i++)
            cyc(1, 5, 0, 1, 0, 5, 1, 0, 0, 1,   STL, STL, STL, "perf_stall");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,       IDL, STL, STL, "perf_tail");
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 1,       FLS, FLS, FLS, "perf_flush");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,       IDL, IDL, IDL, "perf_idle");
        @(negedge clk);
        check("stall_cycles_wrap", 32'(sc1), 32'd1);
        check("flush_events", 32'(fe1), 32'd1);
        check("stall_cycles_n2", 32'(sc2), 32'd2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,       IDL, IDL, IDL, "perf_reset");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,       IDL, IDL, IDL, "perf_after_reset");
        @(negedge clk);
        check("stall_cycles_reset", 32'(sc1), 32'd0);
        check("flush_events_reset", 32'(fe1), 32'd0);
`endif

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
